// File: rtl/aes_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_ctrl_pkg
// Description : Shared types and constants for the RV32 AES core run
//               controller: sequencer state encoding, completion status
//               codes and the ecall instruction encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } run_state_t;

    localparam logic [1:0] ST_NONE    = 2'b00;
    localparam logic [1:0] ST_OK      = 2'b01;
    localparam logic [1:0] ST_ABORT   = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    localparam logic [31:0] ECALL_INSN = 32'h0000_0073;

endpackage : aes_ctrl_pkg
`default_nettype wire

// File: rtl/run_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : run_phase_timer
// Description : 8-bit load-and-count-down timer shared by the CLEAR and
//               DRAIN phases. Loaded with the phase length N on entry; while
//               enabled it counts down and flags expired_o on the Nth
//               (last) cycle of the phase.
// Ports       : clk, rst (sync, active-low)
//               load_i / load_val_i : load the phase length
//               en_i                : phase is active, count down
//               expired_o           : last cycle of the active phase
// Revision    : 1.0 - initial release
// ============================================================================
module run_phase_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       en_i,
    output logic       expired_o
);

    logic [7:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= 8'd0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != 8'd0)) begin
            count_q <= count_q - 8'd1;
        end
    end

    // A count of 1 means this is the final cycle of the phase.
    assign expired_o = en_i && (count_q == 8'd1);

endmodule : run_phase_timer
`default_nettype wire

// File: rtl/aes_run_controller.sv
`default_nettype none
// ============================================================================
// Module      : aes_run_controller
// Description : Run sequencer and BRAM-ownership arbiter for the RV32 AES
//               core. Holds the core in reset while it takes the BRAM,
//               releases it, ends the run on a retired ecall, host abort or
//               (optionally) watchdog expiry, drains memory traffic, hands
//               the BRAM back and holds a sticky status until acknowledged.
// Ports       : clk, rst (sync, active-low)
//               start_in, abort_in, host_ack     : host control
//               instr_valid, instr_word          : retire monitor
//               core_rst_n, core_run, bram_sel   : core / memory-mux control
//               busy, done, status, cycle_count  : host status
// Options     : AES_RUN_WDT_EN - enables the RUN-phase watchdog (WDT_LIMIT)
// Revision    : 1.0 - initial release
// ============================================================================
module aes_run_controller
    import aes_ctrl_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 4,
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned WDT_LIMIT    = 32'h000F_FFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_in,
    input  logic             abort_in,
    input  logic             host_ack,
    input  logic             instr_valid,
    input  logic [31:0]      instr_word,
    output logic             core_rst_n,
    output logic             core_run,
    output logic             bram_sel,
    output logic             busy,
    output logic             done,
    output logic [1:0]       status,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [7:0] C_RESET_LD = RESET_CYCLES[7:0];
    localparam logic [7:0] C_DRAIN_LD = DRAIN_CYCLES[7:0];

    run_state_t       state_q, state_d;
    logic [1:0]       status_q, status_d;
    logic [CNT_W-1:0] cycles_q;
    logic             core_rst_n_q, core_run_q, bram_sel_q, busy_q, done_q;

    logic             tmr_load, tmr_en, tmr_expired;
    logic [7:0]       tmr_load_val;
    logic             is_ecall, wdt_hit, run_start;

    assign is_ecall  = instr_valid && (instr_word == ECALL_INSN);
    assign run_start = (state_q == IDLE) && start_in;
    assign tmr_en    = (state_q == CLEAR) || (state_q == DRAIN);

`ifdef AES_RUN_WDT_EN
    localparam logic [CNT_W-1:0] C_WDT_LIMIT = CNT_W'(WDT_LIMIT);
    logic [CNT_W-1:0] wdt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wdt_q <= '0;
        end else if (run_start) begin
            wdt_q <= '0;
        end else if (state_q == RUN) begin
            wdt_q <= wdt_q + 1'b1;
        end
    end

    // Fire on the cycle whose increment reaches the limit, so a limit of N
    // ends the run after exactly N RUN cycles.
    assign wdt_hit = (CNT_W'(wdt_q + 1'b1) == C_WDT_LIMIT);
`else
    assign wdt_hit = 1'b0;
`endif

    run_phase_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .en_i       (tmr_en),
        .expired_o  (tmr_expired)
    );

    always_comb begin
        state_d      = state_q;
        status_d     = status_q;
        tmr_load     = 1'b0;
        tmr_load_val = C_RESET_LD;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    state_d  = CLEAR;
                    status_d = ST_NONE;
                    tmr_load = 1'b1;
                end
            end
            CLEAR: begin
                // An abort here skips RUN entirely; the core never leaves reset.
                if (abort_in) begin
                    state_d  = DONE;
                    status_d = ST_ABORT;
                end else if (tmr_expired) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                tmr_load_val = C_DRAIN_LD;
                if (abort_in) begin
                    state_d  = DRAIN;
                    status_d = ST_ABORT;
                    tmr_load = 1'b1;
                end else if (is_ecall) begin
                    state_d  = DRAIN;
                    status_d = ST_OK;
                    tmr_load = 1'b1;
                end else if (wdt_hit) begin
                    state_d  = DRAIN;
                    status_d = ST_TIMEOUT;
                    tmr_load = 1'b1;
                end
            end
            DRAIN: begin
                if (tmr_expired) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (host_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it,
    // so they change on the same edge as the state with no input-to-output
    // combinational path.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            status_q     <= ST_NONE;
            cycles_q     <= '0;
            core_rst_n_q <= 1'b0;
            core_run_q   <= 1'b0;
            bram_sel_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            status_q     <= status_d;
            core_rst_n_q <= (state_d == RUN) || (state_d == DRAIN);
            core_run_q   <= (state_d == RUN);
            bram_sel_q   <= (state_d == CLEAR) || (state_d == RUN) || (state_d == DRAIN);
            busy_q       <= (state_d == CLEAR) || (state_d == RUN) || (state_d == DRAIN);
            done_q       <= (state_d == DONE);
            // Every RUN cycle counts, including the terminating one; saturate.
            if (run_start) begin
                cycles_q <= '0;
            end else if ((state_q == RUN) && (cycles_q != {CNT_W{1'b1}})) begin
                cycles_q <= cycles_q + 1'b1;
            end
        end
    end

    assign core_rst_n  = core_rst_n_q;
    assign core_run    = core_run_q;
    assign bram_sel    = bram_sel_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign status      = status_q;
    assign cycle_count = cycles_q;

endmodule : aes_run_controller
`default_nettype wire

// File: doc/aes_run_controller.md
# aes_run_controller

Sequencer and BRAM-ownership arbiter for the RV32 AES core. Takes a host start request, holds the core in reset while the core is given ownership of the instruction/data BRAM, releases the core, and detects termination on a retired `ecall` (32'h00000073), a host abort, or a watchdog expiry. It then drains in-flight memory traffic, returns the BRAM to the host, and holds a sticky completion status until the host acknowledges it. It sits between the host interface and the core's reset, run and memory-mux controls.

## Interface

Parameters:
- `RESET_CYCLES`, default 4: cycles the core is held in reset before release; legal range 1..255.
- `DRAIN_CYCLES`, default 2: cycles after the run ends before the BRAM returns to the host; legal range 1..255.
- `CNT_W`, default 32: width of the run-cycle counter.
- `WDT_LIMIT`, default 32'h000F_FFFF: number of RUN cycles before a timeout; used only with `AES_RUN_WDT_EN`.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-low reset.
- `start_in`  in  1  level; sampled only in IDLE.
- `abort_in`  in  1  level; host abort request.
- `host_ack`  in  1  acknowledges completion; consumed only in DONE.
- `instr_valid`  in  1  `instr_word` is a retiring instruction this cycle.
- `instr_word`  in  32  retiring instruction encoding.
- `core_rst_n`  out  1  active-low reset to the core.
- `core_run`  out  1  core clock-enable / run.
- `bram_sel`  out  1  0 = host owns BRAM, 1 = core owns BRAM.
- `busy`  out  1  high in CLEAR, RUN and DRAIN.
- `done`  out  1  high in DONE.
- `status`  out  2  00 idle/running, 01 ecall ok, 10 abort, 11 timeout; sticky until IDLE.
- `cycle_count`  out  CNT_W  number of RUN cycles in the last or current run.

## Operation

- States:
  - IDLE: `core_rst_n`=0, `bram_sel`=0. If `start_in`=1, go to CLEAR; clear `cycle_count` and `status`.
  - CLEAR: `core_rst_n`=0, `bram_sel`=1. Stay for exactly RESET_CYCLES cycles, then go to RUN.
  - RUN: `core_rst_n`=1, `core_run`=1. `cycle_count` increments every cycle and saturates at all-ones.
  - DRAIN: `core_rst_n`=1, `core_run`=0, `bram_sel`=1. Stay for exactly DRAIN_CYCLES cycles, then go to DONE.
  - DONE: `core_rst_n`=0, `bram_sel`=0, `done`=1. If `host_ack`=1, go to IDLE.
- RUN exit conditions, in priority order:
  1. `abort_in` → DRAIN, `status`=10.
  2. `instr_valid` and `instr_word`==ECALL → DRAIN, `status`=01.
  3. Watchdog count == WDT_LIMIT → DRAIN, `status`=11.
- Abort in CLEAR: go directly to DONE with `status`=10. The core is never released.
- Abort in DRAIN or DONE: ignored.
- `start_in` outside IDLE: ignored. `host_ack` together with `start_in` in DONE: go to IDLE; the start is taken on the next cycle if still high.
- `instr_valid` outside RUN: ignored.
- Reset values of all outputs: `core_rst_n`=0, `core_run`=0, `bram_sel`=0, `busy`=0, `done`=0, `status`=00, `cycle_count`=0. State = IDLE.
- Reset asserted mid-run: the next edge forces all reset values. No drain is performed.

## Timing

- All outputs are registered and decoded from state; there is no combinational path from inputs to outputs.
- `start_in` sampled high at edge T: `busy`=1 and `bram_sel`=1 from T+1. `core_rst_n` rises at T+1+RESET_CYCLES.
- Terminating `ecall` sampled at edge E: `core_run`=0 from E+1. `bram_sel`=0 and `done`=1 at E+1+DRAIN_CYCLES.
- `cycle_count` includes the terminating cycle. An `ecall` retired on the first RUN cycle gives `cycle_count`=1.
- `host_ack` sampled at edge A: `done`=0 at A+1.

## Configuration

- `AES_RUN_WDT_EN` defined: watchdog counter of CNT_W bits runs in RUN. Reaching WDT_LIMIT forces DRAIN with `status`=11.
- `AES_RUN_WDT_EN` undefined: no watchdog logic, `status` is never 11, and a run without `ecall` or abort never ends.

## Structure

- Package `aes_ctrl_pkg`:
  - state enum `run_state_t` (IDLE, CLEAR, RUN, DRAIN, DONE);
  - status constants (`ST_NONE`, `ST_OK`, `ST_ABORT`, `ST_TIMEOUT`);
  - `ECALL_INSN` = 32'h00000073.
- One sub-module, `run_phase_timer`: an 8-bit load-and-count-down timer shared by CLEAR and DRAIN, asserting `expired` on its last cycle.

## Test plan

- Normal run, RESET_CYCLES=4, DRAIN_CYCLES=2: start at T, `ecall` at RUN cycle 10 → `core_rst_n` rises at T+5, `done` at E+3, `status`=01, `cycle_count`=10.
- Non-ecall instruction 32'h00008067 with `instr_valid` → run continues; `busy` stays 1.
- `abort_in` during CLEAR → DONE next cycle, `status`=10, `core_rst_n` never 1.
- `abort_in` and `ecall` in the same RUN cycle → `status`=10.
- `AES_RUN_WDT_EN` with WDT_LIMIT=16 and no `ecall` → DRAIN after 16 RUN cycles, `status`=11, `cycle_count`=16.
- `rst`=0 during RUN → next edge: all outputs 0, IDLE; `start_in` then starts a fresh run with `cycle_count` restarting from 0.
